// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ valid/ready byte producers.
// Optional feature macro UART_TX_ARB_TAG_EN: each grant sends a {4'hA,1'b0,id} header frame before its payload.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       done,
  output logic                       err_timeout
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;

  logic [7:0]    req_byte [NUM_REQ];
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] win_idx, next_ptr;
  logic          win_found, grant_now, timeout_hit, last_frame;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef UART_TX_ARB_TAG_EN
  logic [7:0]    data_reg_q, data_reg_d;
  logic          hdr_q, hdr_d;
  logic [2:0]    win_id3;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_byte[gi]  = req_data[8*gi +: 8];
    assign req_ready[gi] = grant_now && (win_idx == GW'(gi));
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  // The cycle carrying the done pulse is not an arbitration cycle.
  assign grant_now   = (state_q == IDLE) && !tx_busy && !done_q && win_found;
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= 9'(BUSY_TIMEOUT);
  assign next_ptr    = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);

`ifdef UART_TX_ARB_TAG_EN
  assign last_frame = !hdr_q;
`else
  assign last_frame = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant_now) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)          state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_d = last_frame ? IDLE : START;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
    data_reg_d = data_reg_q;
    hdr_d      = hdr_q;
    win_id3    = 3'(win_idx);
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_now) begin
          grant_id_d = win_idx;
          tx_start_d = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          data_reg_d = req_byte[win_idx];
          hdr_d      = 1'b1;
          tx_data_d  = {4'hA, 1'b0, win_id3};
`else
          tx_data_d  = req_byte[win_idx];
`endif
        end
      end
      START: cnt_d = '0;
      WAIT_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (!tx_busy && timeout_hit) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_frame) begin
            done_d   = 1'b1;
            rr_ptr_d = next_ptr;
          end
`ifdef UART_TX_ARB_TAG_EN
          else begin
            tx_start_d = 1'b1;
            tx_data_d  = data_reg_q;
            hdr_d      = 1'b0;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      data_reg_q <= '0;
      hdr_q      <= 1'b0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef UART_TX_ARB_TAG_EN
      data_reg_q <= data_reg_d;
      hdr_q      <= hdr_d;
`endif
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level reference model checks every cycle,
// directed scenarios pin grant order, latencies, timeout, blocking, reset and tag framing.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           arb_busy, done, err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy),
    .done(done), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // transmitter model
  int busy_from = 0, busy_to = 0, xmt_delay = 1, xmt_len = 10;
  bit xmt_dead = 0, xmt_rand = 0, force_busy = 0;

  // reference model
  bit         m_engaged, m_busy_seen, m_start, m_done, m_err;
  int         m_rr, m_win, m_start_cyc, m_gid;
  logic [7:0] m_cur;
  logic [7:0] m_frames[$];

  // observations
  int         n_done = 0, n_err = 0, n_ready = 0, done_cycle = 0, err_cycle = 0;
  int         grant_log[$];
  int         start_cycles[$];
  logic [7:0] start_bytes[$];
  logic [N-1:0] obs_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_engaged = 0; m_busy_seen = 0; m_start = 0; m_done = 0; m_err = 0;
    m_rr = 0; m_win = 0; m_start_cyc = 0; m_gid = 0; m_cur = 8'h00;
    m_frames.delete();
  endtask

  task automatic model_cycle();
    logic [N-1:0] er;
    int w, idx;
    bit was_eng, cool, start_now;
    er = '0; w = -1;
    was_eng = m_engaged; cool = m_done; start_now = m_start;
    chk("arb_busy", 32'(arb_busy), 32'(was_eng));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("done", 32'(done), 32'(m_done));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    m_start = 0; m_done = 0; m_err = 0;
    if (start_now) begin
      if (m_frames.size() > 0) m_cur = m_frames.pop_front();
      m_start_cyc = cyc;
      m_busy_seen = 0;
    end
    chk("tx_data", 32'(tx_data), 32'(m_cur));
    if (!was_eng && !tx_busy && !cool) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (w >= 0) begin
      m_engaged = 1; m_win = w; m_gid = w; m_start = 1;
      m_frames.delete();
`ifdef UART_TX_ARB_TAG_EN
      m_frames.push_back(8'hA0 | 8'(w));
`endif
      m_frames.push_back(req_data[8*w +: 8]);
    end else if (was_eng && !start_now) begin
      if (!m_busy_seen) begin
        if (tx_busy) m_busy_seen = 1;
        else if (cyc - m_start_cyc == BT) begin
          m_err = 1; m_engaged = 0; m_rr = (m_win + 1) % N;
        end
      end else if (!tx_busy) begin
        if (m_frames.size() == 0) begin
          m_done = 1; m_engaged = 0; m_rr = (m_win + 1) % N;
        end else begin
          m_start = 1;
        end
      end
    end
  endtask

  task automatic step();
    cyc++;
    tx_busy = force_busy || (cyc >= busy_from && cyc < busy_to);
    #1;
    obs_ready = req_ready;
    if (!rst) begin
      if (req_ready != '0) begin
        n_ready++;
        for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
      end
      if (tx_start) begin
        start_bytes.push_back(tx_data);
        start_cycles.push_back(cyc);
        if (xmt_rand) begin
          xmt_dead  = ($urandom_range(0, 19) == 0);
          xmt_delay = $urandom_range(1, 20);
          xmt_len   = $urandom_range(1, 12);
        end
        if (xmt_dead) busy_to = 0;
        else begin
          busy_from = cyc + xmt_delay;
          busy_to   = busy_from + xmt_len;
        end
      end
      if (done) begin
        n_done++; done_cycle = cyc;
        $display("xfer done: grant %0d byte %02h cycle %0d", grant_id, tx_data, cyc);
      end
      if (err_timeout) begin
        n_err++; err_cycle = cyc;
        $display("xfer timeout: grant %0d cycle %0d", grant_id, cyc);
      end
      model_cycle();
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    req_valid = '0;
    while ((arb_busy || tx_busy || cyc < busy_to) && k < 300) begin step(); k++; end
    if (k >= 300) bound_fail("drain");
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, e0, r0, s0;
    rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    model_reset();

    // reset values
    do_reset(3);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_arb_busy", 32'(arb_busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // single requester 2
    xmt_delay = 1; xmt_len = 10;
    req_data = $urandom; req_data[23:16] = 8'h5A; req_valid = 4'b0100;
    r0 = n_ready; d0 = n_done; start_bytes.delete(); start_cycles.delete();
    k = 0;
    while (n_ready == r0 && k < 20) begin step(); k++; end
    if (k >= 20) bound_fail("t1_grant_wait");
    chk("t1_ready", 32'(obs_ready), 32'h4);
    req_valid = '0;
    step();
    chk("t1_start_cnt", 32'(start_bytes.size()), 32'd1);
    chk("t1_start_data", 32'(start_bytes[0]), 32'h5A);
    k = 0;
    while (n_done == d0 && k < 60) begin step(); k++; end
    if (k >= 60) bound_fail("t1_done_wait");
    chk("t1_done_cnt", 32'(n_done - d0), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    chk("t1_ready_cycles", 32'(n_ready - r0), 32'd1);
`ifndef UART_TX_ARB_TAG_EN
    chk("t1_done_latency", 32'(done_cycle - start_cycles[0]), 32'd12);
`endif
    drain();

    // all valid, round-robin from reset
    do_reset(2);
    xmt_delay = 2; xmt_len = 5;
    grant_log.delete(); d0 = n_done; req_valid = '1;
    k = 0;
    while (n_done - d0 < 8 && k < 800) begin req_data = $urandom; step(); k++; end
    if (k >= 800) bound_fail("t2_wait");
    if (grant_log.size() < 8) bound_fail("t2_log");
    else for (int i = 0; i < 8; i++) chk("t2_grant_order", 32'(grant_log[i]), 32'(i % 4));
    drain();

    // busy timeout
    do_reset(2);
    xmt_dead = 1; start_cycles.delete(); grant_log.delete();
    e0 = n_err; d0 = n_done; req_valid = 4'b0011;
    k = 0;
    while (n_err == e0 && k < 100) begin step(); k++; end
    if (k >= 100) bound_fail("t3_err_wait");
    chk("t3_err_latency", 32'(err_cycle - start_cycles[0]), 32'd17);
    k = 0;
    while (grant_log.size() < 2 && k < 20) begin step(); k++; end
    if (k >= 20) bound_fail("t3_regrant_wait");
    chk("t3_first_grant", 32'(grant_log[0]), 32'd0);
    chk("t3_next_grant", 32'(grant_log[1]), 32'd1);
    req_valid = '0;
    k = 0;
    while (n_err - e0 < 2 && k < 100) begin step(); k++; end
    if (k >= 100) bound_fail("t3_err2_wait");
    chk("t3_no_done", 32'(n_done - d0), 32'd0);
    xmt_dead = 0;
    drain();

    // arbitration blocked by tx_busy
    do_reset(2);
    xmt_delay = 1; xmt_len = 3;
    force_busy = 1; req_valid = 4'b0011; r0 = n_ready;
    repeat (6) step();
    chk("t4_blocked", 32'(n_ready - r0), 32'd0);
    force_busy = 0;
    step();
    chk("t4_ready", 32'(obs_ready), 32'h1);
    req_valid = '0;
    drain();

    // reset mid-frame
    do_reset(2);
    xmt_delay = 1; xmt_len = 10;
    s0 = start_cycles.size(); req_valid = 4'b0100;
    k = 0;
    while (start_cycles.size() == s0 && k < 30) begin step(); k++; end
    if (k >= 30) bound_fail("t5_start_wait");
    req_valid = 4'b0101;
    repeat (3) step();
    d0 = n_done;
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_req_ready", 32'(req_ready), 32'h0);
    chk("t5_tx_start", 32'(tx_start), 32'h0);
    chk("t5_tx_data", 32'(tx_data), 32'h0);
    chk("t5_grant_id", 32'(grant_id), 32'h0);
    chk("t5_arb_busy", 32'(arb_busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_err", 32'(err_timeout), 32'h0);
    grant_log.delete();
    k = 0;
    while (grant_log.size() == 0 && k < 40) begin step(); k++; end
    if (k >= 40) bound_fail("t5_regrant_wait");
    chk("t5_next_grant", 32'(grant_log[0]), 32'd0);
    chk("t5_no_done", 32'(n_done - d0), 32'd0);
    drain();

    // requester 3 byte C3 (header frame first when tagging is built in)
    do_reset(2);
    xmt_delay = 1; xmt_len = 4;
    req_data = $urandom; req_data[31:24] = 8'hC3; req_valid = 4'b1000;
    start_bytes.delete(); start_cycles.delete(); d0 = n_done; r0 = n_ready;
    k = 0;
    while (n_ready == r0 && k < 20) begin step(); k++; end
    req_valid = '0;
    k = 0;
    while (n_done == d0 && k < 80) begin step(); k++; end
    if (k >= 80) bound_fail("t6_done_wait");
    chk("t6_done_cnt", 32'(n_done - d0), 32'd1);
`ifdef UART_TX_ARB_TAG_EN
    chk("t6_start_cnt", 32'(start_bytes.size()), 32'd2);
    chk("t6_header", 32'(start_bytes[0]), 32'hA3);
    chk("t6_payload", 32'(start_bytes[1]), 32'hC3);
    chk("t6_done_after_payload", 32'(done_cycle > start_cycles[1]), 32'd1);
`else
    chk("t6_start_cnt", 32'(start_bytes.size()), 32'd1);
    chk("t6_payload", 32'(start_bytes[0]), 32'hC3);
`endif
    drain();

    // randomized traffic with random transmitter timing and occasional reset
    do_reset(2);
    d0 = n_done; e0 = n_err; xmt_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      rst       = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; xmt_rand = 0; xmt_dead = 0;
    drain();
    chk("t7_done_seen", 32'(n_done > d0), 32'd1);
    chk("t7_timeout_seen", 32'(n_err > e0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
